// File: rtl/tl_link_pipelined.sv
// tl_link_pipelined: decodes memory-stage loads/stores into tagged A-channel requests that are
// served in order by a FIFO-fed slave memory and answered on a backpressured D channel.
module tl_link_pipelined #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SRC_W      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_WORDS  = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 ir34,
    input  logic [ADDR_W-1:0]           z4_input,
    input  logic [DATA_W-1:0]           md4_input,
    input  logic                        a_ready,
    input  logic                        d_ready,
    output logic                        backpressureslave,
    output logic                        d_valid,
    output logic [3+SRC_W+1+DATA_W-1:0] d_channel,
    output logic                        d_error,
    output logic [SRC_W:0]              outstanding
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int EW = 3 + SRC_W + ADDR_W + DATA_W;
    localparam logic [SRC_W:0]      MAX_OUT   = (SRC_W+1)'(2**SRC_W);
    localparam logic [PW:0]         FIFO_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]   MEM_BYTES = ADDR_W'(MEM_WORDS * 4);

    logic              is_get, is_put, req, accept, fifo_full, pop, d_accept;
    logic              a_valid;
    logic [EW-1:0]     a_beat;
    logic [SRC_W-1:0]  next_src;
    logic [EW-1:0]     fifo [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [2:0]        h_op;
    logic [SRC_W-1:0]  h_src;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    logic              h_err;
    logic [IW-1:0]     h_idx;
    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [2:0]        d_op;
    logic [SRC_W-1:0]  d_src;
    logic              d_err;
    logic [DATA_W-1:0] d_data;
    logic              unused_ir;

    assign unused_ir = ^ir34[31:7];
    assign is_get    = ir34[6:0] == 7'b0000011;
    assign is_put    = ir34[6:0] == 7'b0100011;
    assign fifo_full = count == FIFO_FULL;
    assign accept    = a_valid && a_ready && !fifo_full;
    assign backpressureslave = (a_valid && !accept) || outstanding == MAX_OUT;
    assign req       = (is_get || is_put) && !backpressureslave;
    assign pop       = count != '0 && (!d_valid || d_ready);
    assign d_accept  = d_valid && d_ready;

    assign {h_op, h_src, h_addr, h_data} = fifo[rd_ptr];
    assign h_err = h_addr[1:0] != 2'b00 || h_addr >= MEM_BYTES;
    assign h_idx = h_addr[IW+1:2];

    assign d_channel = d_valid ? {d_op, d_src, d_err, d_data} : '0;
    assign d_error   = d_valid && d_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid     <= 1'b0;
            next_src    <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            d_valid     <= 1'b0;
        end else begin
            if (req) begin
                a_valid  <= 1'b1;
                next_src <= next_src + 1'b1;
            end else if (accept) begin
                a_valid <= 1'b0;
            end
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count       <= count + (PW+1)'(accept) - (PW+1)'(pop);
            outstanding <= outstanding + (SRC_W+1)'(req) - (SRC_W+1)'(d_accept);
            if (pop) d_valid <= 1'b1;
            else if (d_accept) d_valid <= 1'b0;
        end
    end

    // Payload and memory carry no reset; valids above qualify everything visible.
    always_ff @(posedge clk) begin
        if (req) a_beat <= {is_get ? 3'd4 : 3'd0, next_src, z4_input, md4_input};
        if (accept) fifo[wr_ptr] <= a_beat;
        if (pop) begin
            d_op   <= h_op == 3'd4 ? 3'd1 : 3'd0;
            d_src  <= h_src;
            d_err  <= h_err;
            d_data <= (h_err || h_op != 3'd4) ? '0 : mem[h_idx];
        end
        if (pop && !reset && !h_err && h_op == 3'd0) mem[h_idx] <= h_data;
    end
endmodule

// File: tb/tb_tl_link_pipelined.sv
// tb_tl_link_pipelined: directed and random stimulus against an in-order response queue
// and a word-array memory model.
module tb_tl_link_pipelined;
    localparam int AW = 32, DW = 32, SW = 2, FD = 4, MW = 256;
    localparam int CHW = 3 + SW + 1 + DW;
    localparam int MAXO = 1 << SW;

    logic           clk = 0, reset = 1;
    logic [31:0]    ir34 = 0;
    logic [AW-1:0]  z4 = 0;
    logic [DW-1:0]  md4 = 0;
    logic           a_ready = 1, d_ready = 1;
    logic           bp, d_valid, d_error;
    logic [CHW-1:0] d_channel;
    logic [SW:0]    outstanding;

    tl_link_pipelined #(.ADDR_W(AW), .DATA_W(DW), .SRC_W(SW), .FIFO_DEPTH(FD), .MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .ir34(ir34), .z4_input(z4), .md4_input(md4),
        .a_ready(a_ready), .d_ready(d_ready), .backpressureslave(bp), .d_valid(d_valid),
        .d_channel(d_channel), .d_error(d_error), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    int             checks = 0, errors = 0, cyc = 0, nsrc = 0;
    logic [CHW-1:0] exp_q[$];
    logic [DW-1:0]  mm [MW];
    logic           last_bp, last_dv;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic predict(input logic put, input logic [AW-1:0] z, input logic [DW-1:0] md);
        logic err;
        logic [DW-1:0] data;
        err  = z[1:0] != 0 || z >= MW * 4;
        data = (err || put) ? '0 : mm[z >> 2];
        if (put && !err) mm[z >> 2] = md;
        exp_q.push_back({put ? 3'd0 : 3'd1, SW'(nsrc), err, data});
        nsrc = (nsrc + 1) % MAXO;
    endtask

    task automatic step(input logic [31:0] ir, input logic [AW-1:0] z, input logic [DW-1:0] md,
                        input logic ar, input logic dr);
        @(negedge clk);
        ir34 = ir; z4 = z; md4 = md; a_ready = ar; d_ready = dr;
        #1;
        last_bp = bp;
        last_dv = d_valid;
        check("outstanding", outstanding, exp_q.size());
        if (exp_q.size() == MAXO) check("full_stall", bp, 1);
        if (d_valid) begin
            check("d_error_copy", d_error, d_channel[DW]);
            if (dr) begin
                if (exp_q.size() == 0) check("spurious_beat", d_valid, 0);
                else check("d_beat", d_channel, exp_q.pop_front());
            end
        end else begin
            check("d_idle", {d_error, d_channel}, 0);
        end
        if (!bp && (ir[6:0] == 7'h03 || ir[6:0] == 7'h23)) predict(ir[6:0] == 7'h23, z, md);
        @(posedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(0, 0, 0, 1, 1);
        check("drain", exp_q.size(), 0);
        step(0, 0, 0, 1, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; ir34 = 0;
        @(posedge clk);
        #1;
        reset = 0;
        exp_q.delete();
        nsrc = 0;
        check("rst_d_valid", d_valid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_stall", bp, 0);
        check("rst_d_channel", {d_error, d_channel}, 0);
    endtask

    initial begin
        int t0, first;
        logic [31:0] ir;
        logic [AW-1:0] z;
        repeat (2) @(posedge clk);
        do_reset();

        // store then load, with first-response latency
        t0 = cyc;
        first = -1;
        step(32'h23, 32'h10, 32'd20, 1, 1);
        step(32'h03, 32'h10, 0, 1, 1);
        for (int i = 0; i < 10 && first < 0; i++) begin
            step(0, 0, 0, 1, 1);
            if (last_dv) first = cyc - 1;
        end
        check("first_latency", first - t0, 3);
        drain();

        for (int w = 0; w < 16; w++) step(32'h23, AW'(w * 4), $urandom(), 1, 1);
        drain();

        // four loads held off by d_ready=0, then release
        for (int i = 0; i < 4; i++) step(32'h03, AW'(i * 4), 0, 1, 0);
        step(32'h03, 32'h20, 0, 1, 0);
        check("stall_at_full", last_bp, 1);
        repeat (2) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("stall_drop", last_bp, 0);
        drain();

        // A channel throttled with a store pending
        step(32'h23, 32'h20, 32'hABCD, 0, 1);
        repeat (5) begin
            step(32'h03, 32'h24, 0, 0, 1);
            check("a_hold_stall", last_bp, 1);
            check("a_hold_no_d", last_dv, 0);
        end
        drain();
        step(32'h03, 32'h20, 0, 1, 1);
        drain();

        // bad addresses leave memory untouched
        step(32'h23, 32'h12, 32'hDEAD, 1, 1);
        step(32'h23, AW'(MW * 4), 32'hBEEF, 1, 1);
        step(32'h03, 32'h12, 0, 1, 1);
        step(32'h03, AW'(MW * 4), 0, 1, 1);
        step(32'h03, 32'h10, 0, 1, 1);
        drain();

        // source wrap across single loads
        repeat (9) begin
            step(32'h03, AW'($urandom_range(0, 15) * 4), 0, 1, 1);
            drain();
        end

        for (int i = 0; i < 400; i++) begin
            int k;
            ir = $urandom();
            k = $urandom_range(0, 3);
            ir[6:0] = k == 1 ? 7'h23 : k == 2 ? 7'h13 : 7'h03;
            k = $urandom_range(0, 9);
            z = k == 0 ? AW'($urandom_range(0, 15) * 4 + $urandom_range(1, 3)) :
                k == 1 ? AW'(MW * 4 + $urandom_range(0, 100) * 4) : AW'($urandom_range(0, 15) * 4);
            step(ir, z, $urandom(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        drain();

        // reset with requests in flight
        for (int i = 0; i < 3; i++) step(32'h03, AW'(i * 4), 0, 1, 0);
        do_reset();
        step(32'h03, 32'h10, 0, 1, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
